// File: rtl/os_tx_scheduler.sv
// Transmit-side scheduler: per block boundary, chooses an LTSSM ordered set, a SKP
// ordered set or a MAC data block for the shared TX generator.
module os_tx_scheduler #(
  parameter int SKP_INTERVAL_8B10B = 1180,
  parameter int SKP_INTERVAL_128B  = 370,
  parameter int MAX_PENDING        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] gen,
  input  logic [4:0] substate,
  input  logic       linkUp,
  input  logic       osReq,
  input  logic [2:0] osType,
  input  logic [7:0] osCount,
  output logic       osReqAck,
  output logic       osDone,
  input  logic       dataValid,
  input  logic       dataLast,
  output logic       dataReady,
  output logic       genValid,
  output logic       genSel,
  output logic [2:0] genType,
  input  logic       genReady,
  output logic [2:0] skpPending,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, OS = 2'd1, SKP = 2'd2, DATA = 2'd3} state_t;

  localparam logic [2:0] T_EIOS  = 3'd2;
  localparam logic [2:0] T_EIEOS = 3'd3;
  localparam logic [2:0] T_SKP   = 3'd4;
  localparam logic [4:0] SUB_L0  = 5'd10;

  state_t      state_q, state_d, sel_state;
  logic        mid_pkt_q, mid_pkt_d;
  logic        os_lat_q;
  logic [2:0]  os_type_q;
  logic [7:0]  os_cnt_q;
  logic [2:0]  pend_q, pend_d;
  logic [10:0] timer_q, timer_d;
  logic        ack_q;

  logic        abort, xfer, os_xfer, skp_xfer, os_last, eios_done, new_req;
  logic        freeze, expire, lat_eff, pend_avail, data_ok, reselect;
  logic [2:0]  type_eff;
  logic [10:0] interval_m1;

  // Generator handshake: an item transfers on a cycle with genValid & genReady.
  // Once genValid is high, genSel/genType hold until that transfer; in DATA the
  // valid follows the MAC's dataValid, which the MAC holds until dataReady.
  assign genValid   = (state_q == OS) || (state_q == SKP) || ((state_q == DATA) && dataValid);
  assign genSel     = (state_q == DATA);
  assign genType    = (state_q == SKP) ? T_SKP : ((state_q == OS) ? os_type_q : 3'd0);
  assign xfer       = genValid & genReady;
  assign dataReady  = xfer & genSel;
  assign osReqAck   = ack_q;
  assign skpPending = pend_q;
  assign state_dbg  = state_q;

  assign abort     = (substate <= 5'd1);
  assign os_xfer   = xfer && (state_q == OS);
  assign skp_xfer  = xfer && (state_q == SKP);
  assign os_last   = os_xfer && (os_cnt_q == 8'd1);
  assign osDone    = os_last && !abort;
  assign eios_done = osDone && (os_type_q == T_EIOS);
  assign new_req   = !os_lat_q && osReq && !abort;

  // SKP timer halts in detect and while an electrical-idle OS is latched.
  assign freeze      = abort || (os_lat_q && (os_type_q == T_EIOS));
  assign interval_m1 = (gen < 3'd3) ? 11'(SKP_INTERVAL_8B10B - 1) : 11'(SKP_INTERVAL_128B - 1);
  assign expire      = !freeze && (timer_q >= interval_m1);

  always_comb begin
    timer_d = timer_q;
    if (abort || eios_done)   timer_d = 11'd0;
    else if (freeze)          timer_d = timer_q;
    else if (expire)          timer_d = 11'd0;
    else                      timer_d = timer_q + 11'd1;
  end

  always_comb begin
    pend_d = pend_q;
    if (abort || eios_done)
      pend_d = 3'd0;
    else if (expire && !skp_xfer && (pend_q != 3'(MAX_PENDING)))
      pend_d = pend_q + 3'd1;
    else if (skp_xfer && !expire)
      pend_d = pend_q - 3'd1;
  end

  // Selection sees the request/pending state as it stands after this cycle's transfer.
  assign lat_eff    = new_req || (os_lat_q && !os_last);
  assign type_eff   = new_req ? osType : os_type_q;
  assign pend_avail = !eios_done && (skp_xfer ? (pend_q > 3'd1) : (pend_q != 3'd0));
  assign data_ok    = dataValid && (substate == SUB_L0) && linkUp;
  assign reselect   = (state_q == IDLE) ||
                      ((state_q == DATA) && !mid_pkt_q && !dataValid) ||
                      (xfer && !((state_q == DATA) && !dataLast));

  always_comb begin
    sel_state = IDLE;
    if (lat_eff && ((type_eff == T_EIOS) || (type_eff == T_EIEOS))) sel_state = OS;
    else if (pend_avail)                                            sel_state = SKP;
    else if (lat_eff)                                               sel_state = OS;
    else if (data_ok)                                               sel_state = DATA;
  end

  always_comb begin
    state_d   = state_q;
    mid_pkt_d = mid_pkt_q;
    if (abort) begin
      state_d   = IDLE;
      mid_pkt_d = 1'b0;
    end else if (xfer && (state_q == DATA) && !dataLast) begin
      mid_pkt_d = 1'b1;
    end else if (reselect) begin
      state_d   = sel_state;
      mid_pkt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mid_pkt_q <= 1'b0;
      os_lat_q  <= 1'b0;
      os_type_q <= 3'd0;
      os_cnt_q  <= 8'd0;
      pend_q    <= 3'd0;
      timer_q   <= 11'd0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mid_pkt_q <= mid_pkt_d;
      pend_q    <= pend_d;
      timer_q   <= timer_d;
      ack_q     <= new_req;
      if (abort) begin
        os_lat_q <= 1'b0;
      end else if (new_req) begin
        os_lat_q  <= 1'b1;
        os_type_q <= osType;
        os_cnt_q  <= (osCount == 8'd0) ? 8'd1 : osCount;
      end else if (os_xfer) begin
        os_cnt_q <= os_cnt_q - 8'd1;
        if (os_last) os_lat_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_os_tx_scheduler.sv
// Directed bench for os_tx_scheduler: reset, OS repeat, SKP timing/saturation,
// packet atomicity, SKP insertion between OSs, EIOS priority and detect abort.
module tb_os_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] gen;
  logic [4:0] substate;
  logic       link_up;
  logic       os_req;
  logic [2:0] os_type;
  logic [7:0] os_count;
  logic       os_req_ack;
  logic       os_done;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       gen_valid;
  logic       gen_sel;
  logic [2:0] gen_type;
  logic       gen_ready;
  logic [2:0] skp_pending;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  os_tx_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .gen        (gen),
    .substate   (substate),
    .linkUp     (link_up),
    .osReq      (os_req),
    .osType     (os_type),
    .osCount    (os_count),
    .osReqAck   (os_req_ack),
    .osDone     (os_done),
    .dataValid  (data_valid),
    .dataLast   (data_last),
    .dataReady  (data_ready),
    .genValid   (gen_valid),
    .genSel     (gen_sel),
    .genType    (gen_type),
    .genReady   (gen_ready),
    .skpPending (skp_pending),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] g);
    gen = g; substate = 5'd10; link_up = 1'b1;
    os_req = 1'b0; os_type = 3'd0; os_count = 8'd0;
    data_valid = 1'b0; data_last = 1'b0; gen_ready = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3'd1);
    os_req = 1'b1; os_type = 3'd0; os_count = 8'd2;
    step();
    os_req = 1'b0;
    step();
    total++; if (gen_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0b exp=1", gen_valid); end
    #3 reset = 1'b0;
    #1;
    total++; if (gen_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", gen_valid); end
    total++;
    if ({os_req_ack, os_done, data_ready, gen_sel, gen_type} !== 7'd0) begin
      bad++; $display("FAIL rst_outputs got=%b exp=0000000", {os_req_ack, os_done, data_ready, gen_sel, gen_type});
    end
    total++; if (skp_pending !== 3'd0) begin bad++; $display("FAIL rst_pending got=%0d exp=0", skp_pending); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    step();
    reset = 1'b1;
    step();
    total++; if (gen_valid !== 1'b0) begin bad++; $display("FAIL rst_after_valid got=%0b exp=0", gen_valid); end
  endtask

  task automatic test_os_basic();
    do_reset(3'd1);
    os_req = 1'b1; os_type = 3'd0; os_count = 8'd4; gen_ready = 1'b1;
    step();
    total++; if (os_req_ack !== 1'b1) begin bad++; $display("FAIL os_ack got=%0b exp=1", os_req_ack); end
    total++; if (gen_valid !== 1'b1 || gen_type !== 3'd0) begin
      bad++; $display("FAIL os_first got=%0b/%0d exp=1/0", gen_valid, gen_type);
    end
    os_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++; if (os_done !== (i == 4)) begin bad++; $display("FAIL os_done_%0d got=%0b exp=%0b", i, os_done, (i == 4)); end
      total++; if (gen_valid !== 1'b1) begin bad++; $display("FAIL os_valid_%0d got=%0b exp=1", i, gen_valid); end
      step();
    end
    total++; if (gen_valid !== 1'b0 || os_req_ack !== 1'b0) begin
      bad++; $display("FAIL os_end got=%0b/%0b exp=0/0", gen_valid, os_req_ack);
    end
  endtask

  task automatic test_skp_interval();
    do_reset(3'd1);
    repeat (1179) step();
    total++; if (skp_pending !== 3'd0) begin bad++; $display("FAIL skp_early got=%0d exp=0", skp_pending); end
    step();
    total++; if (skp_pending !== 3'd1 || gen_valid !== 1'b0) begin
      bad++; $display("FAIL skp_expire got=%0d/%0b exp=1/0", skp_pending, gen_valid);
    end
    step();
    total++; if (gen_valid !== 1'b1 || gen_sel !== 1'b0 || gen_type !== 3'd4) begin
      bad++; $display("FAIL skp_present got=%0b/%0b/%0d exp=1/0/4", gen_valid, gen_sel, gen_type);
    end
    gen_ready = 1'b1;
    step();
    total++; if (skp_pending !== 3'd0 || gen_valid !== 1'b0) begin
      bad++; $display("FAIL skp_consume got=%0d/%0b exp=0/0", skp_pending, gen_valid);
    end
    gen_ready = 1'b0;
    repeat (8 * 1180) step();
    total++; if (skp_pending !== 3'd7) begin bad++; $display("FAIL skp_saturate got=%0d exp=7", skp_pending); end
    total++; if (gen_valid !== 1'b1 || gen_type !== 3'd4) begin
      bad++; $display("FAIL skp_hold got=%0b/%0d exp=1/4", gen_valid, gen_type);
    end
  endtask

  task automatic test_data_packet();
    do_reset(3'd3);
    repeat (366) step();
    data_valid = 1'b1; data_last = 1'b0;
    step();
    total++; if (gen_valid !== 1'b1 || gen_sel !== 1'b1) begin
      bad++; $display("FAIL pkt_start got=%0b/%0b exp=1/1", gen_valid, gen_sel);
    end
    repeat (3) step();
    total++; if (skp_pending !== 3'd1 || gen_sel !== 1'b1) begin
      bad++; $display("FAIL pkt_expire got=%0d/%0b exp=1/1", skp_pending, gen_sel);
    end
    gen_ready = 1'b1;
    #1;
    total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL pkt_blk1 got=%0b exp=1", data_ready); end
    step();
    total++; if (gen_valid !== 1'b1 || gen_sel !== 1'b1) begin
      bad++; $display("FAIL pkt_blk2 got=%0b/%0b exp=1/1", gen_valid, gen_sel);
    end
    step();
    data_last = 1'b1;
    #1;
    total++; if (data_ready !== 1'b1 || gen_sel !== 1'b1) begin
      bad++; $display("FAIL pkt_blk3 got=%0b/%0b exp=1/1", data_ready, gen_sel);
    end
    step();
    data_valid = 1'b0; data_last = 1'b0;
    #1;
    total++; if (gen_valid !== 1'b1 || gen_sel !== 1'b0 || gen_type !== 3'd4) begin
      bad++; $display("FAIL pkt_skp_after got=%0b/%0b/%0d exp=1/0/4", gen_valid, gen_sel, gen_type);
    end
    step();
    total++; if (skp_pending !== 3'd0 || gen_valid !== 1'b0) begin
      bad++; $display("FAIL pkt_done got=%0d/%0b exp=0/0", skp_pending, gen_valid);
    end
    gen_ready = 1'b0;
  endtask

  task automatic test_os_skp_insert();
    logic [2:0] exp_q[$];
    logic [2:0] exp_t;
    int done_cnt = 0;
    do_reset(3'd3);
    repeat (355) step();
    os_req = 1'b1; os_type = 3'd0; os_count = 8'd16;
    step();
    total++; if (os_req_ack !== 1'b1) begin bad++; $display("FAIL ins_ack got=%0b exp=1", os_req_ack); end
    os_req = 1'b0;
    repeat (384) step();
    total++; if (skp_pending !== 3'd2 || gen_type !== 3'd0) begin
      bad++; $display("FAIL ins_pending got=%0d/%0d exp=2/0", skp_pending, gen_type);
    end
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd4);
    repeat (15) exp_q.push_back(3'd0);
    gen_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      exp_t = exp_q.pop_front();
      #1;
      total++; if (gen_valid !== 1'b1 || gen_type !== exp_t) begin
        bad++; $display("FAIL ins_item_%0d got=%0b/%0d exp=1/%0d", i, gen_valid, gen_type, exp_t);
      end
      if (os_done === 1'b1) done_cnt++;
      step();
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ins_done_count got=%0d exp=1", done_cnt); end
    total++; if (gen_valid !== 1'b0 || skp_pending !== 3'd0) begin
      bad++; $display("FAIL ins_end got=%0b/%0d exp=0/0", gen_valid, skp_pending);
    end
    gen_ready = 1'b0;
  endtask

  task automatic test_eios_first();
    do_reset(3'd3);
    data_valid = 1'b1; data_last = 1'b0; gen_ready = 1'b1;
    step();
    step();
    data_valid = 1'b0;
    repeat (1108) step();
    total++; if (skp_pending !== 3'd3 || gen_valid !== 1'b0) begin
      bad++; $display("FAIL eios_pend got=%0d/%0b exp=3/0", skp_pending, gen_valid);
    end
    os_req = 1'b1; os_type = 3'd2; os_count = 8'd0;
    step();
    total++; if (os_req_ack !== 1'b1 || gen_sel !== 1'b1) begin
      bad++; $display("FAIL eios_ack got=%0b/%0b exp=1/1", os_req_ack, gen_sel);
    end
    os_req = 1'b0; data_valid = 1'b1; data_last = 1'b1;
    step();
    total++; if (gen_valid !== 1'b1 || gen_sel !== 1'b0 || gen_type !== 3'd2) begin
      bad++; $display("FAIL eios_first got=%0b/%0b/%0d exp=1/0/2", gen_valid, gen_sel, gen_type);
    end
    data_valid = 1'b0; data_last = 1'b0; gen_ready = 1'b0;
    repeat (400) step();
    total++; if (skp_pending !== 3'd3) begin bad++; $display("FAIL eios_frozen got=%0d exp=3", skp_pending); end
    gen_ready = 1'b1;
    #1;
    total++; if (os_done !== 1'b1) begin bad++; $display("FAIL eios_done got=%0b exp=1", os_done); end
    step();
    total++; if (skp_pending !== 3'd0 || gen_valid !== 1'b0) begin
      bad++; $display("FAIL eios_clear got=%0d/%0b exp=0/0", skp_pending, gen_valid);
    end
    gen_ready = 1'b0;
    repeat (369) step();
    total++; if (skp_pending !== 3'd0) begin bad++; $display("FAIL eios_timer_early got=%0d exp=0", skp_pending); end
    step();
    total++; if (skp_pending !== 3'd1) begin bad++; $display("FAIL eios_timer_restart got=%0d exp=1", skp_pending); end
  endtask

  task automatic test_abort();
    do_reset(3'd3);
    os_req = 1'b1; os_type = 3'd0; os_count = 8'd2;
    step();
    os_req = 1'b0;
    repeat (370) step();
    total++; if (skp_pending !== 3'd1 || gen_valid !== 1'b1) begin
      bad++; $display("FAIL abort_pre got=%0d/%0b exp=1/1", skp_pending, gen_valid);
    end
    substate = 5'd0;
    step();
    total++; if (gen_valid !== 1'b0 || skp_pending !== 3'd0 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL abort_state got=%0b/%0d/%0d exp=0/0/0", gen_valid, skp_pending, state_dbg);
    end
    gen_ready = 1'b1;
    #1;
    total++; if (os_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%0b exp=0", os_done); end
    substate = 5'd10;
    step();
    step();
    total++; if (gen_valid !== 1'b0 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL abort_latch_cleared got=%0b/%0d exp=0/0", gen_valid, state_dbg);
    end
    gen_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_os_basic();
    test_skp_interval();
    test_data_packet();
    test_os_skp_insert();
    test_eios_first();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/os_tx_scheduler.md
Name: os_tx_scheduler

Overview:
- Transmit-side scheduler for the PCIe MAC ordered-set/data path; decides, per block boundary, whether the shared TX generator emits an LTSSM-requested ordered set (TS1/TS2/EIOS/EIEOS), a SKP ordered set, or MAC data.
- Owns the SKP interval timer, the pending-SKP accounting and the LTSSM OS repeat counter.
- Sits between the LTSSM/MAC data source and the ordered-set/data generator, mirroring the RX ordered-set decoder.

Parameters:
- SKP_INTERVAL_8B10B, 1180, cycles between SKP schedules for gen 1/2
- SKP_INTERVAL_128B, 370, cycles between SKP schedules for gen 3..5
- MAX_PENDING, 7, saturation value of the pending-SKP counter (3-bit)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- gen  input  3  current generation, 1..5
- substate  input  5  LTSSM substate (detectQuiet=0, detectActive=1, L0=10)
- linkUp  input  1  link-up indication
- osReq  input  1  LTSSM ordered-set request, level
- osType  input  3  0=TS1, 1=TS2, 2=EIOS, 3=EIEOS
- osCount  input  8  number of OSs to send; 0 treated as 1
- osReqAck  output  1  one-cycle pulse: request accepted
- osDone  output  1  one-cycle pulse: last OS of request transferred
- dataValid  input  1  MAC has a data block
- dataLast  input  1  current data block ends a packet
- dataReady  output  1  data block consumed this cycle (= genValid & genReady & genSel)
- genValid  output  1  generator request valid
- genSel  output  1  0=ordered set, 1=data
- genType  output  3  0..3 as osType, 4=SKP (don't-care when genSel=1)
- genReady  input  1  generator accepts current item
- skpPending  output  3  pending SKP count

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous, active-low. On reset all outputs 0, FSM=IDLE, timer, pending, repeat counter cleared.
- SKP timer: interval = SKP_INTERVAL_8B10B if gen<3, else SKP_INTERVAL_128B. Increments every cycle unless substate<=1 or current/latched type is EIOS. At interval-1, wraps to 0 and pending increments (saturates at MAX_PENDING; further expiries dropped).
- FSM states: IDLE, OS, SKP, DATA.
- Selection, made in IDLE and at every transfer (genValid&genReady). Priority:
  - (1) latched OS request with type EIOS/EIEOS;
  - (2) pending>0;
  - (3) latched or new OS request;
  - (4) dataValid when substate==L0 and linkUp.
  - Otherwise go to IDLE.
- Data packet atomicity: in DATA, SKP and OS are not selected until a transfer with dataLast=1. Mid-packet transfers stay in DATA if dataValid, else hold genValid=0 in DATA.
- OS request: sampled when no request is latched; osReqAck pulses the cycle it is latched. Type and count (0 becomes 1) are loaded; osReq is ignored while latched.
  - Each OS transfer decrements count; the final transfer pulses osDone and clears the latch.
  - A SKP may be inserted between consecutive OSs of a request (priority 2).
- SKP transfer decrements pending. If a timer expiry and a SKP transfer occur in the same cycle, pending is unchanged.
- Handshake: once genValid=1, genSel/genType hold until genReady. Next item is presented the cycle after transfer (back-to-back allowed; no bubble).
- EIOS completion clears pending and resets the timer.
- substate<=1 (detect): synchronous abort next cycle. FSM=IDLE, genValid=0 (overrides handshake hold), latch/pending/timer cleared, no osDone.
- gen change: takes effect on the next timer compare; the current count is not reset.
- Latency: osReq to first genValid = 1 cycle from IDLE; to osReqAck = 1 cycle.

Test Plan:
- Reset low mid-transfer, then release -> all outputs 0, skpPending=0, FSM idle. First osReq TS1 count 4 gives osReqAck next cycle, then 4 TS1 transfers with genReady=1 and osDone on the 4th.
- gen=1, no traffic, 1180 cycles -> skpPending becomes 1. genValid with genType=4 next cycle; transfer drops pending to 0. With genReady=0 for 8 intervals, pending saturates at 7.
- L0, 3-block packet (dataLast on 3rd) while the SKP timer expires on block 1 -> data blocks uninterrupted, SKP issued immediately after block 3.
- TS1 count 16 with pending=2 raised mid-sequence -> two SKPs inserted at OS boundaries, 16 TS1 total, osDone once.
- EIOS request while pending=3 and data idle -> EIOS first. After osDone, skpPending=0 and the timer stays frozen while latched.
- substate forced to 0 during an OS stall (genReady=0) -> genValid=0 next cycle, no osDone, skpPending=0.
